// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int CMD_RW_BIT = 7;

    localparam logic [BYTE_W-1:0] DUMMY_DEFAULT = 8'h00;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RFETCH,
        RWAIT,
        RDATA
    } state_t;

    // Byte counter increment that sticks at the top value instead of wrapping.
    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
        return (v == {BYTE_W{1'b1}}) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI byte engine / register bank and the frame controller.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
) ();
    import spi_pkg::*;

    // SPI byte-engine side
    logic              ss_n;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic [BYTE_W-1:0] tx_byte;
    logic              tx_load;

    // Register-bank side
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [BYTE_W-1:0] reg_wdata;
    logic              reg_rd_en;
    logic [BYTE_W-1:0] reg_rdata;

    // Frame status
    logic              busy;
    logic              frame_done;
    logic [BYTE_W-1:0] frame_bytes;

    // The controller itself.
    modport slave (
        input  ss_n, rx_valid, rx_byte, reg_rdata,
        output tx_byte, tx_load, reg_addr, reg_wr_en, reg_wdata, reg_rd_en,
               busy, frame_done, frame_bytes
    );

    // The environment: byte engine plus register bank.
    modport master (
        output ss_n, rx_valid, rx_byte, reg_rdata,
        input  tx_byte, tx_load, reg_addr, reg_wr_en, reg_wdata, reg_rd_en,
               busy, frame_done, frame_bytes
    );

endinterface

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-clk edge pulses
// on the synchronized value. Everything resets to 1 (the idle level of ss_n).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    // chain_reg[STAGES-1] is the synchronized level, chain_reg[STAGES] its previous value.
    logic [STAGES:0] chain_reg;

    // Shift the raw input through the synchronizer and history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '1;
        end else begin
            chain_reg <= {chain_reg[STAGES-1:0], din};
        end
    end

    assign rise = chain_reg[STAGES-1] & ~chain_reg[STAGES];
    assign fall = ~chain_reg[STAGES-1] & chain_reg[STAGES];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller behind an SPI slave byte engine: first byte of each
// chip-select frame is a command (bit 7 = read, low bits = start address),
// the rest is a write burst or a read burst against a local register bank.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int                ADDR_W   = 7,
    parameter bit                AUTO_INC = 1'b1,
    parameter logic [BYTE_W-1:0] DUMMY    = DUMMY_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    spi_reg_ctrl_if.slave bus
);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [BYTE_W-1:0] count_reg, count_next;
    logic              wr_en_reg;
    logic [BYTE_W-1:0] wdata_reg;
    logic [BYTE_W-1:0] tx_byte_reg;
    logic              frame_done_reg;
    logic [BYTE_W-1:0] frame_bytes_reg;

    // Chip select is active-low: ss_n falling starts a frame, rising ends it.
    logic ss_n_rise, ss_n_fall;
    logic frame_start, frame_end;

    // Per-cycle decisions from the sequencer.
    logic byte_in;
    logic take_cmd, take_wr, take_rd;
    logic rd_strobe, tx_strobe, capture_rd;
    logic start_frame, end_frame;

    sync_edge #(
        .STAGES (2)
    ) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.ss_n),
        .rise (ss_n_rise),
        .fall (ss_n_fall)
    );

    assign frame_start = ss_n_fall;
    assign frame_end   = ss_n_rise;

    // Any byte seen inside a frame counts, including one that coincides with the frame end.
    assign byte_in    = bus.rx_valid && (state_reg != IDLE);
    assign count_next = byte_in ? sat_inc(count_reg) : count_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobe decode; a frame end overrides everything except byte capture.
    always_comb begin
        state_next  = state_reg;
        take_cmd    = 1'b0;
        take_wr     = 1'b0;
        take_rd     = 1'b0;
        rd_strobe   = 1'b0;
        tx_strobe   = 1'b0;
        capture_rd  = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next  = CMD;
                    start_frame = 1'b1;
                    tx_strobe   = 1'b1;
                end
            end
            CMD: begin
                if (bus.rx_valid) begin
                    take_cmd   = 1'b1;
                    state_next = bus.rx_byte[CMD_RW_BIT] ? RFETCH : WDATA;
                end
            end
            WDATA: begin
                take_wr = bus.rx_valid;
            end
            RFETCH: begin
                rd_strobe  = 1'b1;
                state_next = RWAIT;
            end
            RWAIT: begin
                tx_strobe  = 1'b1;
                capture_rd = 1'b1;
                state_next = RDATA;
            end
            RDATA: begin
                if (bus.rx_valid) begin
                    take_rd    = 1'b1;
                    state_next = RFETCH;
                end
            end
            default: state_next = IDLE;
        endcase
        if ((state_reg != IDLE) && frame_end) begin
            state_next = IDLE;
            end_frame  = 1'b1;
            rd_strobe  = 1'b0;
            tx_strobe  = 1'b0;
            capture_rd = 1'b0;
        end
    end

    // Address, byte count, write pipeline, transmit holding register and frame status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg        <= '0;
            count_reg       <= '0;
            wr_en_reg       <= 1'b0;
            wdata_reg       <= '0;
            tx_byte_reg     <= DUMMY;
            frame_done_reg  <= 1'b0;
            frame_bytes_reg <= '0;
        end else begin
            wr_en_reg      <= take_wr;
            frame_done_reg <= end_frame;

            if (take_wr) begin
                wdata_reg <= bus.rx_byte;
            end

            // The write address is presented during the write strobe and advances afterwards.
            if (take_cmd) begin
                addr_reg <= bus.rx_byte[ADDR_W-1:0];
            end else if (AUTO_INC && (wr_en_reg || take_rd)) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end

            if (start_frame) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_next;
            end

            if (end_frame) begin
                tx_byte_reg     <= DUMMY;
                frame_bytes_reg <= count_next;
            end else if (capture_rd) begin
                tx_byte_reg <= bus.reg_rdata;
            end
        end
    end

    // Read data arrives one clk after the strobe; pass it straight through on the load cycle.
    assign bus.tx_byte     = capture_rd ? bus.reg_rdata : tx_byte_reg;
    assign bus.tx_load     = tx_strobe;
    assign bus.reg_addr    = addr_reg;
    assign bus.reg_wr_en   = wr_en_reg;
    assign bus.reg_wdata   = wdata_reg;
    assign bus.reg_rd_en   = rd_strobe;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.frame_done  = frame_done_reg;
    assign bus.frame_bytes = frame_bytes_reg;

endmodule
